// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives ALU op, datapath mux selects, enables and memory strobes.
module multi_cycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  output logic [2:0]       ALU_operation,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             pc_load,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_IF  = 4'd0;
  localparam logic [3:0] S_ID  = 4'd1;
  localparam logic [3:0] S_MA  = 4'd2;
  localparam logic [3:0] S_MR  = 4'd3;
  localparam logic [3:0] S_MWB = 4'd4;
  localparam logic [3:0] S_MW  = 4'd5;
  localparam logic [3:0] S_EXR = 4'd6;
  localparam logic [3:0] S_RWB = 4'd7;
  localparam logic [3:0] S_BR  = 4'd8;
  localparam logic [3:0] S_JMP = 4'd9;
  localparam logic [3:0] S_EXI = 4'd10;
  localparam logic [3:0] S_IWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [2:0] rtype_op;
  logic       rtype_ok;
  logic       rtype_ovf_chk;
  logic [2:0] itype_op;
  logic       take;

  // R-type function decode; unsupported functs still add but never write back.
  always_comb begin
    rtype_op      = ALU_ADD;
    rtype_ok      = 1'b1;
    rtype_ovf_chk = 1'b0;
    case (funct)
      6'b100000: begin rtype_op = ALU_ADD; rtype_ovf_chk = 1'b1; end
      6'b100010: begin rtype_op = ALU_SUB; rtype_ovf_chk = 1'b1; end
      6'b100100: rtype_op = ALU_AND;
      6'b100101: rtype_op = ALU_OR;
      6'b100111: rtype_op = ALU_NOR;
      6'b101010: rtype_op = ALU_SLT;
      6'b100110: rtype_op = ALU_XOR;
      6'b000010: rtype_op = ALU_SRL;
      default:   rtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    itype_op = ALU_ADD;
    case (opcode)
      OP_ANDI: itype_op = ALU_AND;
      OP_ORI:  itype_op = ALU_OR;
      OP_SLTI: itype_op = ALU_SLT;
      default: itype_op = ALU_ADD;
    endcase
  end

  assign take = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW:                    state_d = S_MA;
          OP_RTYPE:                        state_d = S_EXR;
          OP_BEQ, OP_BNE:                  state_d = S_BR;
          OP_J:                            state_d = S_JMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXI;
          default:                         state_d = S_IF;
        endcase
      end
      S_MA:    state_d = (opcode == OP_LW) ? S_MR : S_MW;
      S_MR:    state_d = S_MWB;
      S_EXR:   state_d = S_RWB;
      S_EXI:   state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  // Every arrival in IF from elsewhere retires one instruction, including illegal ops.
  always_comb begin
    retired_d = retired_q;
    if ((state_d == S_IF) && (state_q != S_IF))
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    ALU_operation = ALU_ADD;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_ID:  ALUSrcB = 2'b11;
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MR: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MW: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXR: begin
        ALUSrcA       = 1'b1;
        ALU_operation = rtype_op;
      end
      // ALU selects held from EXR so the overflow flag is still valid here.
      S_RWB: begin
        ALUSrcA       = 1'b1;
        ALU_operation = rtype_op;
        RegDst        = 1'b1;
        RegWrite      = rtype_ok & ~(rtype_ovf_chk & overflow);
      end
      S_BR: begin
        ALUSrcA       = 1'b1;
        ALU_operation = ALU_SUB;
        PCSource      = 2'b01;
        PCWriteCond   = 1'b1;
      end
      S_JMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_EXI: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = itype_op;
      end
      S_IWB: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = itype_op;
        RegWrite      = 1'b1;
      end
      default: ALU_operation = ALU_ADD;
    endcase
  end

  assign pc_load = PCWrite | (PCWriteCond & take);
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class through its
// state sequence and checks strobes, ALU ops, branch resolution and counter wrap.
module tb_multi_cycle_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             overflow;
  logic [2:0]       ALU_operation;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       PCSource;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             pc_load;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  int n_checks;
  int n_pass;

  multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .ALU_operation(ALU_operation), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .pc_load(pc_load), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .state(state), .retired(retired)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_illegal(input logic [31:0] exp_ret);
    opcode = 6'b111111;
    tick();
    check("ill_id", 32'(state), 32'd1);
    tick();
    check("ill_if", 32'(state), 32'd0);
    check("ill_ret", 32'(retired), exp_ret);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    opcode   = 6'b000000;
    funct    = 6'b100000;
    zero     = 1'b0;
    overflow = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ret", 32'(retired), 32'd0);
    check("rst_memread", 32'(MemRead), 32'd1);
    check("rst_irwrite", 32'(IRWrite), 32'd1);
    check("rst_aluop", 32'(ALU_operation), 32'd2);
    check("rst_pcload", 32'(pc_load), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // lw: 0,1,2,3,4,0
    opcode = 6'b100011;
    @(posedge clk); #1;
    check("lw_id", 32'(state), 32'd1);
    check("lw_id_srcb", 32'(ALUSrcB), 32'd3);
    tick();
    check("lw_ma", 32'(state), 32'd2);
    check("lw_ma_srcb", 32'(ALUSrcB), 32'd2);
    tick();
    check("lw_mr", 32'(state), 32'd3);
    check("lw_mr_memread", 32'(MemRead), 32'd1);
    check("lw_mr_iord", 32'(IorD), 32'd1);
    tick();
    check("lw_mwb", 32'(state), 32'd4);
    check("lw_mwb_regwrite", 32'(RegWrite), 32'd1);
    check("lw_mwb_memtoreg", 32'(MemtoReg), 32'd1);
    tick();
    check("lw_if", 32'(state), 32'd0);
    check("lw_ret", 32'(retired), 32'd1);

    // R-type sub, overflow suppresses writeback
    opcode = 6'b000000;
    funct  = 6'b100010;
    tick();
    tick();
    check("sub_exr", 32'(state), 32'd6);
    check("sub_exr_op", 32'(ALU_operation), 32'd6);
    check("sub_exr_srca", 32'(ALUSrcA), 32'd1);
    overflow = 1'b1;
    tick();
    check("sub_rwb", 32'(state), 32'd7);
    check("sub_rwb_op", 32'(ALU_operation), 32'd6);
    check("sub_ovf_regwrite", 32'(RegWrite), 32'd0);
    overflow = 1'b0;
    #1;
    check("sub_noovf_regwrite", 32'(RegWrite), 32'd1);
    check("sub_regdst", 32'(RegDst), 32'd1);
    tick();
    check("sub_ret", 32'(retired), 32'd2);

    // unsupported funct: add op, never writes
    funct = 6'b111111;
    tick();
    tick();
    check("badf_op", 32'(ALU_operation), 32'd2);
    tick();
    check("badf_regwrite", 32'(RegWrite), 32'd0);
    tick();
    check("badf_ret", 32'(retired), 32'd3);

    // beq
    opcode = 6'b000100;
    zero   = 1'b1;
    tick();
    tick();
    check("beq_br", 32'(state), 32'd8);
    check("beq_op", 32'(ALU_operation), 32'd6);
    check("beq_z1_pcload", 32'(pc_load), 32'd1);
    zero = 1'b0;
    #1;
    check("beq_z0_pcload", 32'(pc_load), 32'd0);
    tick();
    check("beq_ret", 32'(retired), 32'd4);

    // bne
    opcode = 6'b000101;
    zero   = 1'b1;
    tick();
    tick();
    check("bne_z1_pcload", 32'(pc_load), 32'd0);
    zero = 1'b0;
    #1;
    check("bne_z0_pcload", 32'(pc_load), 32'd1);
    check("bne_pcsrc", 32'(PCSource), 32'd1);
    tick();
    check("bne_ret", 32'(retired), 32'd5);

    // j
    opcode = 6'b000010;
    tick();
    tick();
    check("j_state", 32'(state), 32'd9);
    check("j_pcsrc", 32'(PCSource), 32'd2);
    check("j_pcload", 32'(pc_load), 32'd1);
    tick();
    check("j_ret", 32'(retired), 32'd6);

    // ori
    opcode = 6'b001101;
    tick();
    tick();
    check("ori_exi", 32'(state), 32'd10);
    check("ori_op", 32'(ALU_operation), 32'd1);
    check("ori_srcb", 32'(ALUSrcB), 32'd2);
    tick();
    check("ori_iwb", 32'(state), 32'd11);
    check("ori_regwrite", 32'(RegWrite), 32'd1);
    check("ori_regdst", 32'(RegDst), 32'd0);
    tick();
    check("ori_if", 32'(state), 32'd0);
    check("ori_ret", 32'(retired), 32'd7);

    // sw
    opcode = 6'b101011;
    tick();
    tick();
    tick();
    check("sw_mw", 32'(state), 32'd5);
    check("sw_memwrite", 32'(MemWrite), 32'd1);
    check("sw_regwrite", 32'(RegWrite), 32'd0);
    tick();
    check("sw_ret", 32'(retired), 32'd8);

    // illegal ops run the counter up to 15, then wrap
    for (int i = 9; i <= 15; i++) run_illegal(32'(i));
    run_illegal(32'd0);

    // async reset in the middle of MR
    opcode = 6'b100011;
    tick();
    tick();
    tick();
    check("mr_state", 32'(state), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_ret", 32'(retired), 32'd0);
    check("async_memread", 32'(MemRead), 32'd1);
    check("async_irwrite", 32'(IRWrite), 32'd1);
    check("async_memwrite", 32'(MemWrite), 32'd0);
    check("async_regwrite", 32'(RegWrite), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_id", 32'(state), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
